// File: rtl/apb_cmd_master.sv
// APB3 initiator: turns a valid/ready command stream into single APB transfers and
// returns one response per accepted command (slave error, decode error or timeout).
module apb_cmd_master #(
    parameter int unsigned ADDR_WIDTH     = 5,
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned NUM_SLAVES     = 2,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                             PCLK,
    input  logic                             PRESETN,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic                             req_write,
    input  logic [3:0]                       req_sel,
    input  logic [ADDR_WIDTH-1:0]            req_addr,
    input  logic [DATA_WIDTH-1:0]            req_wdata,
    output logic                             rsp_valid,
    output logic [DATA_WIDTH-1:0]            rsp_rdata,
    output logic                             rsp_err,
    output logic                             rsp_timeout,
    output logic                             busy,
    output logic [ADDR_WIDTH-1:0]            PADDR,
    output logic [NUM_SLAVES-1:0]            PSEL,
    output logic                             PENABLE,
    output logic                             PWRITE,
    output logic [DATA_WIDTH-1:0]            PWDATA,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA,
    input  logic [NUM_SLAVES-1:0]            PREADY,
    input  logic [NUM_SLAVES-1:0]            PSLVERR
);

    localparam int unsigned CNT_WIDTH =
        (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_LIMIT   = CNT_WIDTH'(TIMEOUT_CYCLES);
    localparam logic [4:0]           SLAVE_COUNT = 5'(NUM_SLAVES);

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StAccess,
        StResp
    } state_e;

    state_e                 state_q;
    logic                   write_q;
    logic [3:0]             sel_q;
    logic [CNT_WIDTH-1:0]   tcnt_q;

    logic [NUM_SLAVES-1:0]  psel_dec;
    logic                   sel_ready;
    logic                   sel_err;
    logic [DATA_WIDTH-1:0]  sel_rdata;
    logic [CNT_WIDTH-1:0]   tcnt_inc;
    logic                   timed_out;
    logic                   sel_in_range;

    // Decode the incoming select and mux back only the addressed slave's response.
    always_comb begin
        psel_dec  = '0;
        sel_ready = 1'b0;
        sel_err   = 1'b0;
        sel_rdata = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            psel_dec[k] = (req_sel == 4'(k));
            if (sel_q == 4'(k)) begin
                sel_ready = PREADY[k];
                sel_err   = PSLVERR[k];
                sel_rdata = PRDATA[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign sel_in_range = ({1'b0, req_sel} < SLAVE_COUNT);

    // Saturating wait counter; the limit test looks at the value after this cycle's wait.
    assign tcnt_inc  = (&tcnt_q) ? tcnt_q : tcnt_q + 1'b1;
    assign timed_out = (TIMEOUT_CYCLES != 0) && (tcnt_inc == CNT_LIMIT);

    assign req_ready = (state_q == StIdle) && PRESETN;
    assign busy      = (state_q != StIdle);

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state_q     <= StIdle;
            write_q     <= 1'b0;
            sel_q       <= '0;
            tcnt_q      <= '0;
            PADDR       <= '0;
            PSEL        <= '0;
            PENABLE     <= 1'b0;
            PWRITE      <= 1'b0;
            PWDATA      <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        write_q <= req_write;
                        sel_q   <= req_sel;
                        tcnt_q  <= '0;
                        if (sel_in_range) begin
                            PSEL    <= psel_dec;
                            PADDR   <= req_addr;
                            PWRITE  <= req_write;
                            PWDATA  <= req_wdata;
                            state_q <= StSetup;
                        end else begin
                            // Unknown slave: answer straight away, never touch the bus.
                            rsp_valid   <= 1'b1;
                            rsp_err     <= 1'b1;
                            rsp_timeout <= 1'b0;
                            rsp_rdata   <= '0;
                            state_q     <= StResp;
                        end
                    end
                end
                StSetup: begin
                    PENABLE <= 1'b1;
                    state_q <= StAccess;
                end
                StAccess: begin
                    if (sel_ready) begin
                        PSEL        <= '0;
                        PENABLE     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= sel_err;
                        rsp_timeout <= 1'b0;
                        rsp_rdata   <= (!write_q && !sel_err) ? sel_rdata : '0;
                        state_q     <= StResp;
                    end else begin
                        tcnt_q <= tcnt_inc;
                        if (timed_out) begin
                            PSEL        <= '0;
                            PENABLE     <= 1'b0;
                            rsp_valid   <= 1'b1;
                            rsp_err     <= 1'b1;
                            rsp_timeout <= 1'b1;
                            rsp_rdata   <= '0;
                            state_q     <= StResp;
                        end
                    end
                end
                StResp: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Bench for apb_cmd_master: directed vector table, randomized commands against a
// response model, plus hand-written reset-during-access sequence.
module tb_apb_cmd_master;

    localparam int AW = 5;
    localparam int DW = 8;
    localparam int NS = 2;
    localparam int TO = 16;

    logic             PCLK = 1'b0;
    logic             PRESETN = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic             req_write = 1'b0;
    logic [3:0]       req_sel = '0;
    logic [AW-1:0]    req_addr = '0;
    logic [DW-1:0]    req_wdata = '0;
    logic             rsp_valid;
    logic [DW-1:0]    rsp_rdata;
    logic             rsp_err;
    logic             rsp_timeout;
    logic             busy;
    logic [AW-1:0]    PADDR;
    logic [NS-1:0]    PSEL;
    logic             PENABLE;
    logic             PWRITE;
    logic [DW-1:0]    PWDATA;
    logic [NS*DW-1:0] PRDATA;
    logic [NS-1:0]    PREADY;
    logic [NS-1:0]    PSLVERR;

    int total = 0;
    int bad   = 0;

    // Slave model configuration: target slave, wait states, error flag, read data.
    logic [3:0] cfg_sel = '0;
    int         cfg_waits = 0;
    bit         cfg_slverr = 1'b0;
    logic [7:0] cfg_rdata = '0;
    int         acc_cnt;
    logic       ready_sel;

    apb_cmd_master #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .NUM_SLAVES    (NS),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .PCLK       (PCLK),
        .PRESETN    (PRESETN),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_sel    (req_sel),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .rsp_timeout(rsp_timeout),
        .busy       (busy),
        .PADDR      (PADDR),
        .PSEL       (PSEL),
        .PENABLE    (PENABLE),
        .PWRITE     (PWRITE),
        .PWDATA     (PWDATA),
        .PRDATA     (PRDATA),
        .PREADY     (PREADY),
        .PSLVERR    (PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    always @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) acc_cnt <= 0;
        else if (PENABLE && PSEL != '0) acc_cnt <= acc_cnt + 1;
        else acc_cnt <= 0;
    end

    assign ready_sel = (acc_cnt >= cfg_waits);

    // Non-selected slaves answer with the opposite ready/error and inverted data.
    always_comb begin
        PREADY  = '0;
        PSLVERR = '0;
        PRDATA  = '0;
        for (int k = 0; k < NS; k++) begin
            if (cfg_sel == 4'(k)) begin
                PREADY[k]          = ready_sel;
                PSLVERR[k]         = cfg_slverr;
                PRDATA[k*DW +: DW] = cfg_rdata;
            end else begin
                PREADY[k]          = ~ready_sel;
                PSLVERR[k]         = ~cfg_slverr;
                PRDATA[k*DW +: DW] = ~cfg_rdata;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Expected response straight from the transfer rules.
    task automatic model(input bit w, input logic [3:0] s, input int waits, input bit slverr,
                         input logic [7:0] prd, output bit e_err, output bit e_to,
                         output logic [7:0] e_rd, output int e_lat);
        if (int'(s) >= NS) begin
            e_err = 1'b1; e_to = 1'b0; e_rd = 8'h00; e_lat = 1;
        end else if (waits >= TO) begin
            e_err = 1'b1; e_to = 1'b1; e_rd = 8'h00; e_lat = TO + 2;
        end else begin
            e_err = slverr; e_to = 1'b0; e_rd = (!w && !slverr) ? prd : 8'h00; e_lat = 3 + waits;
        end
    endtask

    task automatic run_cmd(input string tag, input bit w, input logic [3:0] s,
                           input logic [4:0] a, input logic [7:0] d, input int waits,
                           input bit slverr, input logic [7:0] prd, input bit e_err,
                           input bit e_to, input logic [7:0] e_rd, input int e_lat);
        int lat = 0;
        int pen = 0;
        bit got = 1'b0;
        bit psel_seen = 1'b0, sel_bad = 1'b0, ctl_bad = 1'b0, setup_bad = 1'b0;
        bit end_bad = 1'b0, rdy_bad = 1'b0;
        bit decode = (int'(s) >= NS);
        logic [NS-1:0] exp_psel = '0;
        logic r_err = 1'b0, r_to = 1'b0;
        logic [7:0] r_rd = '0;
        if (!decode) exp_psel[int'(s)] = 1'b1;
        cfg_sel = s; cfg_waits = waits; cfg_slverr = slverr; cfg_rdata = prd;
        @(negedge PCLK);
        req_valid = 1'b1; req_write = w; req_sel = s; req_addr = a; req_wdata = d;
        #1 chk({tag, ":ready_before"}, req_ready, 1);
        @(posedge PCLK);
        for (int c = 1; c <= 60 && !got; c++) begin
            @(negedge PCLK);
            req_valid = 1'b0;
            if (c == 1 && !decode && !(PSEL != '0 && !PENABLE)) setup_bad = 1'b1;
            if (req_ready || !busy) rdy_bad = 1'b1;
            if (PSEL != '0) begin
                psel_seen = 1'b1;
                if (PSEL !== exp_psel) sel_bad = 1'b1;
                if (PADDR !== a || PWRITE !== w || PWDATA !== d) ctl_bad = 1'b1;
            end
            if (PENABLE) pen++;
            if (rsp_valid) begin
                got = 1'b1; lat = c;
                r_err = rsp_err; r_to = rsp_timeout; r_rd = rsp_rdata;
                if (PSEL != '0 || PENABLE) end_bad = 1'b1;
            end
        end
        chk({tag, ":rsp_seen"}, got, 1);
        chk({tag, ":latency"}, lat, e_lat);
        chk({tag, ":err"}, r_err, e_err);
        chk({tag, ":timeout"}, r_to, e_to);
        chk({tag, ":rdata"}, r_rd, e_rd);
        chk({tag, ":penable_cycles"}, pen, decode ? 0 : e_lat - 2);
        chk({tag, ":psel_seen"}, psel_seen, !decode);
        chk({tag, ":psel_onehot"}, sel_bad, 0);
        chk({tag, ":ctl_stable"}, ctl_bad, 0);
        chk({tag, ":setup_phase"}, setup_bad, 0);
        chk({tag, ":bus_idle_at_rsp"}, end_bad, 0);
        chk({tag, ":ready_low_busy"}, rdy_bad, 0);
        if (got) begin
            @(negedge PCLK);
            chk({tag, ":rsp_one_cycle"}, rsp_valid, 0);
            chk({tag, ":err_hold"}, rsp_err, e_err);
            chk({tag, ":rdata_hold"}, rsp_rdata, e_rd);
            chk({tag, ":ready_after"}, req_ready, 1);
        end
    endtask

    typedef struct {
        bit         w;
        logic [3:0] s;
        logic [4:0] a;
        logic [7:0] d;
        int         waits;
        bit         slverr;
        logic [7:0] prd;
        bit         e_err;
        bit         e_to;
        logic [7:0] e_rd;
        int         e_lat;
    } vec_t;

    vec_t vecs[8];

    initial begin
        bit         w, se, e_err, e_to;
        logic [3:0] s;
        logic [4:0] a;
        logic [7:0] d, prd, e_rd;
        int         wt, e_lat;
        bit         rsp_leak;

        vecs[0] = '{1'b1, 4'd0,  5'h00, 8'hA5, 0,  1'b0, 8'h77, 1'b0, 1'b0, 8'h00, 3};
        vecs[1] = '{1'b0, 4'd1,  5'h04, 8'h11, 2,  1'b0, 8'h3C, 1'b0, 1'b0, 8'h3C, 5};
        vecs[2] = '{1'b0, 4'd0,  5'h1F, 8'h22, 0,  1'b1, 8'h55, 1'b1, 1'b0, 8'h00, 3};
        vecs[3] = '{1'b0, 4'd5,  5'h02, 8'h33, 0,  1'b0, 8'h44, 1'b1, 1'b0, 8'h00, 1};
        vecs[4] = '{1'b1, 4'd1,  5'h0A, 8'h5A, 15, 1'b0, 8'h99, 1'b0, 1'b0, 8'h00, 18};
        vecs[5] = '{1'b0, 4'd0,  5'h07, 8'h66, 16, 1'b0, 8'hC3, 1'b1, 1'b1, 8'h00, 18};
        vecs[6] = '{1'b1, 4'd15, 5'h10, 8'hF0, 0,  1'b0, 8'h12, 1'b1, 1'b0, 8'h00, 1};
        vecs[7] = '{1'b1, 4'd1,  5'h03, 8'h0F, 1,  1'b1, 8'hAB, 1'b1, 1'b0, 8'h00, 4};

        // Reset state
        #2;
        chk("rst:req_ready", req_ready, 0);
        chk("rst:rsp_valid", rsp_valid, 0);
        chk("rst:psel", PSEL, 0);
        chk("rst:penable", PENABLE, 0);
        chk("rst:paddr", PADDR, 0);
        chk("rst:busy", busy, 0);
        chk("rst:rsp_err", rsp_err, 0);
        repeat (2) @(negedge PCLK);
        PRESETN = 1'b1;
        #1 chk("rst:ready_after_release", req_ready, 1);

        foreach (vecs[i]) begin
            run_cmd($sformatf("vec%0d", i), vecs[i].w, vecs[i].s, vecs[i].a, vecs[i].d,
                    vecs[i].waits, vecs[i].slverr, vecs[i].prd, vecs[i].e_err, vecs[i].e_to,
                    vecs[i].e_rd, vecs[i].e_lat);
        end

        for (int i = 0; i < 40; i++) begin
            w   = 1'($urandom_range(0, 1));
            s   = 4'($urandom_range(0, 3));
            a   = 5'($urandom);
            d   = 8'($urandom);
            wt  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(14, 17))
                                              : int'($urandom_range(0, 3));
            se  = ($urandom_range(0, 3) == 0);
            prd = 8'($urandom);
            model(w, s, wt, se, prd, e_err, e_to, e_rd, e_lat);
            run_cmd($sformatf("rnd%0d", i), w, s, a, d, wt, se, prd, e_err, e_to, e_rd, e_lat);
        end

        // Reset while the transfer is stuck in ACCESS.
        cfg_sel = 4'd1; cfg_waits = 1000; cfg_slverr = 1'b0; cfg_rdata = 8'h5E;
        @(negedge PCLK);
        req_valid = 1'b1; req_write = 1'b0; req_sel = 4'd1; req_addr = 5'h09; req_wdata = 8'h00;
        @(posedge PCLK);
        @(negedge PCLK);
        req_valid = 1'b0;
        @(negedge PCLK);
        chk("mid:in_access", PENABLE, 1);
        #2 PRESETN = 1'b0;
        #1;
        chk("mid:psel_dropped", PSEL, 0);
        chk("mid:penable_dropped", PENABLE, 0);
        chk("mid:rsp_valid", rsp_valid, 0);
        chk("mid:req_ready_in_reset", req_ready, 0);
        chk("mid:busy", busy, 0);
        rsp_leak = 1'b0;
        repeat (3) begin
            @(negedge PCLK);
            if (rsp_valid) rsp_leak = 1'b1;
        end
        PRESETN = 1'b1;
        #1 chk("mid:ready_after_release", req_ready, 1);
        for (int c = 0; c < 4; c++) begin
            @(negedge PCLK);
            if (rsp_valid) rsp_leak = 1'b1;
        end
        chk("mid:no_response", rsp_leak, 0);
        run_cmd("post_rst", 1'b0, 4'd1, 5'h04, 8'h00, 0, 1'b0, 8'hC7, 1'b0, 1'b0, 8'hC7, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
